// File: rtl/add_unit_if.sv
// add_unit_if: operand/result bundle for add_unit.
//   master : drives in_valid, sub, operand1, operand2; observes all results.
//   slave  : the adder itself; consumes operands, drives combinational
//            sum + NZCV flags and the registered sum_q / flags_q / out_valid.
// flags_q packing is {negative, zero, carry_out, overflow}, MSB first.
interface add_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic [WIDTH-1:0] sum_q;
  logic [3:0]       flags_q;
  logic             out_valid;

  modport master (
    output in_valid, sub, operand1, operand2,
    input  sum, carry_out, overflow, zero, negative, sum_q, flags_q, out_valid
  );

  modport slave (
    input  in_valid, sub, operand1, operand2,
    output sum, carry_out, overflow, zero, negative, sum_q, flags_q, out_valid
  );
endinterface

// File: rtl/add_unit.sv
// add_unit: WIDTH-bit integer adder/subtractor with NZCV flags.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus.slave  : in_valid, sub, operand1, operand2 in;
//                sum, carry_out, overflow, zero, negative out (combinational);
//                sum_q, flags_q {N,Z,C,V}, out_valid out (registered, 1 cycle).
// Optional build macro ADD_SATURATE_EN: on signed overflow, sum/sum_q clamp
// to the most positive/negative value; overflow and carry_out still report
// the raw add, zero/negative follow the clamped value.
// WIDTH must be at least 2.
module add_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  add_unit_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             cout;
  logic             z;
  logic             n;

  // Subtract is a + ~b + 1, so carry_out = 1 means "no borrow".
  assign b_eff    = bus.sub ? ~bus.operand2 : bus.operand2;
  assign add_full = {1'b0, bus.operand1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.sub};
  assign raw      = add_full[WIDTH-1:0];
  assign cout     = add_full[WIDTH];

  // Using the effective (possibly inverted) second operand makes one rule
  // cover both modes: same-sign inputs to the adder, result sign differs.
  assign ovf = (bus.operand1[MSB] == b_eff[MSB]) && (raw[MSB] != bus.operand1[MSB]);

`ifdef ADD_SATURATE_EN
  // On overflow the true result has operand1's sign in both modes.
  assign res = !ovf            ? raw :
               bus.operand1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res = raw;
`endif

  assign z = (res == '0);
  assign n = res[MSB];

  assign bus.sum       = res;
  assign bus.carry_out = cout;
  assign bus.overflow  = ovf;
  assign bus.zero      = z;
  assign bus.negative  = n;

  // Registered copy; data only loads on in_valid so idle/X operands
  // never reach sum_q/flags_q.
  logic [WIDTH-1:0] sum_r;
  logic [3:0]       flags_r;
  logic             vld_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      flags_r <= 4'b0000;
      vld_r   <= 1'b0;
    end else begin
      vld_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= res;
        flags_r <= {n, z, cout, ovf};
      end
    end
  end

  assign bus.sum_q     = sum_r;
  assign bus.flags_q   = flags_r;
  assign bus.out_valid = vld_r;

endmodule

// File: tb/tb_add_unit.sv
// tb_add_unit: self-checking bench for add_unit (WIDTH = 32).
// Combinational results are compared against a signed/unsigned integer
// reference model; registered results go through a scoreboard queue that a
// separate monitor drains one entry per clock while enabled.
module tb_add_unit;

  logic clk;
  logic rst_n;

  add_unit_if #(.WIDTH(32)) bus ();

  add_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } res_t;

  typedef struct {
    logic        ov;
    logic [31:0] sq;
    logic [3:0]  fq;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  logic mon_en = 1'b0;
  logic [31:0] m_sq = '0;
  logic [3:0]  m_fq = '0;

  // Reference: true signed result in 64-bit arithmetic, carry from unsigned
  // comparison, overflow from range check.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   r;
    longint sa, sb, ua, ub, t;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    t  = s ? sa - sb : sa + sb;
    r.c = s ? (ua >= ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    r.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef ADD_SATURATE_EN
    if (r.v) t = (t > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
    r.sum = t[31:0];
    r.z   = (r.sum == 32'd0);
    r.n   = r.sum[31];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Drive operands, settle, compare combinational outputs to the model.
  task automatic comb(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    bus.sub = s; bus.operand1 = a; bus.operand2 = b;
    #10;
    r = model(a, b, s);
    chk({nm, "_sum"}, bus.sum, r.sum);
    chk({nm, "_nzcv"}, {bus.negative, bus.zero, bus.carry_out, bus.overflow},
        {r.n, r.z, r.c, r.v});
  endtask

  // One clocked operation: call just after a negedge; returns at the next.
  task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    exp_t e;
    bus.in_valid = v; bus.sub = s; bus.operand1 = a; bus.operand2 = b;
    r = model(a, b, s);
    if (v) begin
      m_sq = r.sum;
      m_fq = {r.n, r.z, r.c, r.v};
    end
    e.ov = v; e.sq = m_sq; e.fq = m_fq;
    sbq.push_back(e);
    #5;
    chk("step_sum", bus.sum, r.sum);
    chk("step_nzcv", {bus.negative, bus.zero, bus.carry_out, bus.overflow},
        {r.n, r.z, r.c, r.v});
    @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per clock while enabled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 64'd0, 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("mon_out_valid", bus.out_valid, e.ov);
          chk("mon_sum_q", bus.sum_q, e.sq);
          chk("mon_flags_q", bus.flags_q, e.fq);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.sub = 1'b0; bus.operand1 = '0; bus.operand2 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_sum_q", bus.sum_q, 32'd0);
    chk("rst_flags_q", bus.flags_q, 4'd0);
    chk("rst_out_valid", bus.out_valid, 1'b0);

    // Combinational path, exercised while still in reset.
    for (int i = 0; i < 10; i++) comb("rand_add", 1'b0, $urandom, $urandom);

    comb("carry_zero", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("cz_sum_k", bus.sum, 32'h0);
    chk("cz_nzcv_k", {bus.negative, bus.zero, bus.carry_out, bus.overflow}, 4'b0110);

    comb("sovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
`ifdef ADD_SATURATE_EN
    chk("sovf_sum_k", bus.sum, 32'h7FFF_FFFF);
    chk("sovf_nv_k", {bus.negative, bus.overflow}, 2'b01);
`else
    chk("sovf_sum_k", bus.sum, 32'h8000_0000);
    chk("sovf_nv_k", {bus.negative, bus.overflow}, 2'b11);
`endif

    comb("sub_neg", 1'b1, 32'h5, 32'h7);
    chk("sub_neg_sum_k", bus.sum, 32'hFFFF_FFFE);
    chk("sub_neg_nc_k", {bus.negative, bus.carry_out}, 2'b10);

    comb("sub_eq", 1'b1, 32'h1234_5678, 32'h1234_5678);
    chk("sub_eq_sum_k", bus.sum, 32'h0);
    chk("sub_eq_zc_k", {bus.zero, bus.carry_out}, 2'b11);

    comb("zero_m1", 1'b1, 32'h0, 32'h1);
    chk("zero_m1_sum_k", bus.sum, 32'hFFFF_FFFF);
    chk("zero_m1_c_k", bus.carry_out, 1'b0);

    comb("min_m1", 1'b1, 32'h8000_0000, 32'h1);

    // Registered stage.
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 32'd3, 32'd4);
    chk("reg_sum_q_k", bus.sum_q, 32'd7);
    chk("reg_flags_q_k", bus.flags_q, 4'b0000);
    chk("reg_valid_k", bus.out_valid, 1'b1);
    step(1'b0, 1'b0, 32'd100, 32'd200);
    chk("hold_sum_q_k", bus.sum_q, 32'd7);
    chk("hold_valid_k", bus.out_valid, 1'b0);
    mon_en = 1'b0;

    // Async reset between edges, with a valid operation pending.
    bus.in_valid = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    chk("arst_sum_q", bus.sum_q, 32'd0);
    chk("arst_flags_q", bus.flags_q, 4'd0);
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_comb_sum", bus.sum, 32'd300);
    @(posedge clk);
    #1;
    chk("arst_held_valid", bus.out_valid, 1'b0);
    chk("arst_held_sum_q", bus.sum_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_sq = '0;
    m_fq = '0;
    sbq.delete();

    // Randomized clocked traffic.
    mon_en = 1'b1;
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
